mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Brief   : Iterative multiply/divide sequencer owning the HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_op_0,
  input  logic [DATA_WIDTH-1:0] i_op_1,
  input  logic                  i_cancel,
  input  logic                  i_hi_we,
  input  logic                  i_lo_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_div_by_zero,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;
  localparam logic [CNT_WIDTH-1:0] c_last_iter = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]              r_state, w_next_state;
  logic                    w_busy;
  logic [1:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a, r_b, r_raw_0;
  logic                    r_neg_q, r_neg_r, r_dz;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc, w_acc_next;
  logic [DATA_WIDTH-1:0]   r_hi, r_lo;
  logic                    r_done, r_dbz;

  logic                    w_neg_0, w_neg_1;
  logic [DATA_WIDTH-1:0]   w_abs_0, w_abs_1;
  logic [DATA_WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quot, w_rem, w_fix_hi, w_fix_lo;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= c_idle;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (i_start) w_next_state = c_run;
      c_run: begin
        if (i_cancel)                 w_next_state = c_idle;
        else if (r_cnt == c_last_iter) w_next_state = c_fix;
      end
      c_fix:   w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = (r_state == c_run) || (r_state == c_fix);
  end

  // Operands are reduced to magnitudes; signs are reapplied in FIX.
  always_comb begin
    w_neg_0 = ~i_op[0] & i_op_0[DATA_WIDTH-1];
    w_neg_1 = ~i_op[0] & i_op_1[DATA_WIDTH-1];
    w_abs_0 = w_neg_0 ? -i_op_0 : i_op_0;
    w_abs_1 = w_neg_1 ? -i_op_1 : i_op_1;
  end

  // One iteration: shift-add for MUL, restoring trial subtract for DIV.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_div_shift = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
    w_div_diff  = w_div_shift - {1'b0, r_b};
    if (r_op[1]) begin
      if (w_div_diff[DATA_WIDTH])
        w_acc_next = {w_div_shift[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};
      else
        w_acc_next = {w_div_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
    end else begin
      w_acc_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quot   = r_neg_q ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];
    w_rem    = r_neg_r ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH] : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
    w_fix_hi = r_op[1] ? (r_dz ? r_raw_0 : w_rem) : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    w_fix_lo = r_op[1] ? (r_dz ? '1 : w_quot)     : w_prod[DATA_WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_raw_0 <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == c_idle && i_start) begin
      r_op    <= i_op;
      r_a     <= w_abs_0;
      r_b     <= w_abs_1;
      r_raw_0 <= i_op_0;
      r_neg_q <= w_neg_0 ^ w_neg_1;
      r_neg_r <= w_neg_0;
      r_dz    <= (i_op_1 == '0);
      r_cnt   <= '0;
      r_acc   <= {{DATA_WIDTH{1'b0}}, (i_op[1] ? w_abs_0 : w_abs_1)};
    end else if (r_state == c_run) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  // A cancel arriving in FIX wins over the result write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (r_state == c_fix && !i_cancel) begin
      r_hi   <= w_fix_hi;
      r_lo   <= w_fix_lo;
      r_done <= 1'b1;
      r_dbz  <= r_op[1] & r_dz;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (r_state == c_idle) begin
        if (i_hi_we) r_hi <= i_wdata;
        if (i_lo_we) r_lo <= i_wdata;
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_ctrl
// Brief   : Self-checking bench for mdu_ctrl against a 64-bit arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, cancel, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] op_0, op_1, wdata;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_op call
  logic [W-1:0] obs_hi, obs_lo;
  logic         obs_dz, obs_busy_at_done, obs_busy_after_abort, obs_done_seen;
  int           obs_lat, obs_busy_cnt;

  mdu_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_op_0(op_0), .i_op_1(op_1), .i_cancel(cancel),
    .i_hi_we(hi_we), .i_lo_we(lo_we), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [1:0] m_op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] e_hi, e_lo, output logic e_dz);
    longint sa, sb, sp;
    logic [63:0] up;
    e_dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (m_op)
      2'b00: begin sp = sa * sb; {e_hi, e_lo} = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {e_hi, e_lo} = up; end
      default: begin
        if (b == '0) begin
          e_dz = 1'b1; e_hi = a; e_lo = '1;
        end else if (m_op == 2'b10) begin
          e_lo = 32'(sa / sb); e_hi = 32'(sa % sb);
        end else begin
          e_lo = a / b; e_hi = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 200));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one op and watches up to 40 edges; edge 1 is the one sampling start.
  // pulse_at/cancel_at/rst_at inject a one-cycle event after that edge (0 = never).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, b, input bit align,
                        input int pulse_at, input int cancel_at, input int rst_at);
    int n, abort_at;
    abort_at = (cancel_at != 0) ? cancel_at : rst_at;
    if (align) @(negedge clk);
    op = o; op_0 = a; op_1 = b; start = 1'b1;
    @(posedge clk);
    n = 1; obs_done_seen = 0; obs_lat = -1; obs_busy_cnt = 0;
    obs_busy_after_abort = 1'bx; obs_busy_at_done = 1'bx;
    while (n <= 40) begin
      @(negedge clk);
      if (done && !obs_done_seen) begin
        obs_done_seen = 1; obs_lat = n; obs_hi = hi; obs_lo = lo;
        obs_dz = dbz; obs_busy_at_done = busy;
      end else if (busy && !obs_done_seen) begin
        obs_busy_cnt++;
      end
      if (abort_at != 0 && n == abort_at + 1) obs_busy_after_abort = busy;
      start = 1'b0; cancel = 1'b0; rst = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1; op = o ^ 2'b10; op_0 = 32'($urandom); op_1 = 32'($urandom);
      end
      if (n == cancel_at) cancel = 1'b1;
      if (n == rst_at) rst = 1'b1;
      if (obs_done_seen && abort_at == 0) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; cancel = 0; hi_we = 0; lo_we = 0;
    op = '0; op_0 = '0; op_1 = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, dbz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, dbz});
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [W-1:0] t_a  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                               32'h8000_0000, 32'd100, 32'hFFFF_FFFB};
    logic [W-1:0] t_b  [7] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE,
                               32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] t_hi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                               32'd0, 32'd100, 32'hFFFF_FFFB};
    logic [W-1:0] t_lo [7] = '{32'hFFFF_FFEB, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic         t_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1, 0, 0, 0);
      checks++;
      if (obs_lat != LAT || obs_busy_cnt != LAT - 1 || obs_busy_at_done !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d busy_at_done=%b expected %0d/%0d/0",
                 i, obs_lat, obs_busy_cnt, obs_busy_at_done, LAT, LAT - 1);
      end
      checks++;
      if (obs_hi !== t_hi[i] || obs_lo !== t_lo[i] || obs_dz !== t_dz[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h dz=%b expected %h/%h/%b",
                 i, obs_hi, obs_lo, obs_dz, t_hi[i], t_lo[i], t_dz[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]   r_op;
    logic [W-1:0] a, b, e_hi, e_lo;
    logic         e_dz;
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      ref_model(r_op, a, b, e_hi, e_lo, e_dz);
      run_op(r_op, a, b, 1, 0, 0, 0);
      checks++;
      if (obs_lat != LAT || obs_hi !== e_hi || obs_lo !== e_lo || obs_dz !== e_dz) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b expected %0d/%h/%h/%b",
                 i, r_op, a, b, obs_lat, obs_hi, obs_lo, obs_dz, LAT, e_hi, e_lo, e_dz);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] e_hi, e_lo;
    logic         e_dz;
    ref_model(2'b00, 32'd12345, 32'hFFFF_FF00, e_hi, e_lo, e_dz);
    run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1, 10, 0, 0);
    checks++;
    if (obs_lat != LAT || obs_hi !== e_hi || obs_lo !== e_lo) begin
      errors++;
      $display("FAIL start_while_busy: lat=%0d hi=%h lo=%h expected %0d/%h/%h",
               obs_lat, obs_hi, obs_lo, LAT, e_hi, e_lo);
    end
    // The ignored request must not have queued a second operation.
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_not_queued: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e_hi, e_lo;
    logic         e_dz;
    ref_model(2'b11, 32'd1000, 32'd7, e_hi, e_lo, e_dz);
    run_op(2'b11, 32'd1000, 32'd7, 1, 0, 0, 0);
    checks++;
    if (obs_hi !== e_hi || obs_lo !== e_lo) begin
      errors++; $display("FAIL b2b_first: hi=%h lo=%h expected %h/%h", obs_hi, obs_lo, e_hi, e_lo);
    end
    ref_model(2'b00, 32'hFFFF_FFF0, 32'h0001_0003, e_hi, e_lo, e_dz);
    run_op(2'b00, 32'hFFFF_FFF0, 32'h0001_0003, 0, 0, 0, 0);
    checks++;
    if (obs_lat != LAT || obs_hi !== e_hi || obs_lo !== e_lo) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d hi=%h lo=%h expected %0d/%h/%h",
               obs_lat, obs_hi, obs_lo, LAT, e_hi, e_lo);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] p_hi, p_lo, e_hi, e_lo;
    logic         e_dz;
    run_op(2'b01, 32'h1234_5678, 32'h0000_0100, 1, 0, 0, 0);
    p_hi = hi; p_lo = lo;
    run_op(2'b10, 32'hFFFF_F000, 32'd3, 1, 0, 10, 0);
    checks++;
    if (obs_busy_after_abort !== 1'b0 || obs_done_seen) begin
      errors++;
      $display("FAIL cancel_flow: busy_after=%b done_seen=%0d expected 0/0",
               obs_busy_after_abort, obs_done_seen);
    end
    checks++;
    if (hi !== p_hi || lo !== p_lo) begin
      errors++; $display("FAIL cancel_hilo: hi=%h lo=%h expected %h/%h", hi, lo, p_hi, p_lo);
    end
    // Cancel in IDLE is a no-op; the next op must run normally.
    ref_model(2'b10, 32'hFFFF_F000, 32'd3, e_hi, e_lo, e_dz);
    run_op(2'b10, 32'hFFFF_F000, 32'd3, 1, 0, 0, 0);
    checks++;
    if (obs_lat != LAT || obs_hi !== e_hi || obs_lo !== e_lo) begin
      errors++;
      $display("FAIL after_cancel: lat=%0d hi=%h lo=%h expected %0d/%h/%h",
               obs_lat, obs_hi, obs_lo, LAT, e_hi, e_lo);
    end
  endtask

  task automatic test_reset_mid();
    run_op(2'b00, 32'hFFFF_FFFF, 32'd5, 1, 0, 0, 20);
    checks++;
    if (obs_busy_after_abort !== 1'b0 || obs_done_seen || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy_after=%b done_seen=%0d hi=%h lo=%h expected 0/0/0/0",
               obs_busy_after_abort, obs_done_seen, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_idle: hi=%h expected 12345678", hi);
    end
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mtlo_idle: hi=%h lo=%h expected 12345678/9abcdef0", hi, lo);
    end
    // Write together with start lands, and the result later overwrites it.
    op = 2'b01; op_0 = 32'd6; op_1 = 32'd7; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0; wdata = 32'hDEAD_BEEF;
    checks++;
    if (hi !== 32'h55 || lo !== 32'h55) begin
      errors++; $display("FAIL mt_with_start: hi=%h lo=%h expected 55/55", hi, lo);
    end
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'h55 || lo !== 32'h55) begin
      errors++; $display("FAIL mt_while_busy: hi=%h lo=%h expected 55/55", hi, lo);
    end
    n = 2;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done || n != LAT || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL mt_overwritten: done=%b at=%0d hi=%h lo=%h expected 1/%0d/0/2a",
               done, n, hi, lo, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    test_mthi_mtlo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
